// File: rtl/cpu.sv
`default_nettype none
// cpu: single-cycle RV32I core with combinational instruction ROM and data memory ports.
// Build macro CPU_REGFILE_RESET_EN: when defined, x1..x31 are cleared by the asynchronous reset.
module cpu #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rstn,
  output logic [XLEN-1:0]   rom_addr,
  input  logic [31:0]       rom_data,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_r,
  output logic [XLEN/8-1:0] mem_w,
  output logic [XLEN-1:0]   mem_din,
  input  logic [XLEN-1:0]   mem_dout
);

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   regs_q [32];
  logic [6:0]        opcode, f7;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        f3;
  logic [XLEN-1:0]   rs1_v, rs2_v;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
  logic              rd_we, ld_r, taken;
  logic [XLEN-1:0]   rd_val, st_din, dm_addr;
  logic [XLEN/8-1:0] st_w;

  assign opcode = rom_data[6:0];
  assign rd     = rom_data[11:7];
  assign f3     = rom_data[14:12];
  assign rs1    = rom_data[19:15];
  assign rs2    = rom_data[24:20];
  assign f7     = rom_data[31:25];

  assign imm_i = {{(XLEN-12){rom_data[31]}}, rom_data[31:20]};
  assign imm_s = {{(XLEN-12){rom_data[31]}}, rom_data[31:25], rom_data[11:7]};
  assign imm_b = {{(XLEN-13){rom_data[31]}}, rom_data[31], rom_data[7], rom_data[30:25],
                  rom_data[11:8], 1'b0};
  assign imm_u = {rom_data[31:12], 12'd0};
  assign imm_j = {{(XLEN-21){rom_data[31]}}, rom_data[31], rom_data[19:12], rom_data[20],
                  rom_data[30:21], 1'b0};

  assign rs1_v = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rs2_v = (rs2 == 5'd0) ? '0 : regs_q[rs2];

  // alt selects SUB for op 000 and arithmetic shift for op 101
  function automatic logic [XLEN-1:0] alu(input logic [2:0] op, input logic alt,
                                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] sra;
    sra = $signed(a) >>> b[4:0];
    alu = '0;
    case (op)
      3'b000:  alu = alt ? (a - b) : (a + b);
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011:  alu = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? sra : (a >> b[4:0]);
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  always_comb begin
    pc_d    = pc_q + XLEN'(4);
    rd_we   = 1'b0;
    rd_val  = '0;
    ld_r    = 1'b0;
    st_w    = '0;
    st_din  = '0;
    dm_addr = '0;
    taken   = 1'b0;
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_val = pc_q + imm_u; end
      OP_JAL: begin
        rd_we  = 1'b1;
        rd_val = pc_q + XLEN'(4);
        pc_d   = pc_q + imm_j;
      end
      OP_JALR: if (f3 == 3'b000) begin
        rd_we  = 1'b1;
        rd_val = pc_q + XLEN'(4);
        pc_d   = (rs1_v + imm_i) & ~XLEN'(1);
      end
      OP_BRANCH: begin
        case (f3)
          3'b000:  taken = (rs1_v == rs2_v);
          3'b001:  taken = (rs1_v != rs2_v);
          3'b100:  taken = ($signed(rs1_v) <  $signed(rs2_v));
          3'b101:  taken = ($signed(rs1_v) >= $signed(rs2_v));
          3'b110:  taken = (rs1_v <  rs2_v);
          3'b111:  taken = (rs1_v >= rs2_v);
          default: taken = 1'b0;
        endcase
        if (taken) pc_d = pc_q + imm_b;
      end
      OP_LOAD: begin
        ld_r = 1'b1;
        case (f3)
          3'b000:  rd_val = {{(XLEN-8){mem_dout[7]}}, mem_dout[7:0]};
          3'b001:  rd_val = {{(XLEN-16){mem_dout[15]}}, mem_dout[15:0]};
          3'b010:  rd_val = mem_dout;
          3'b100:  rd_val = {{(XLEN-8){1'b0}}, mem_dout[7:0]};
          3'b101:  rd_val = {{(XLEN-16){1'b0}}, mem_dout[15:0]};
          default: ld_r = 1'b0;
        endcase
        rd_we = ld_r;
        if (ld_r) dm_addr = rs1_v + imm_i;
      end
      OP_STORE: begin
        case (f3)
          3'b000:  begin st_w = 4'b0001; st_din = {{(XLEN-8){1'b0}}, rs2_v[7:0]}; end
          3'b001:  begin st_w = 4'b0011; st_din = {{(XLEN-16){1'b0}}, rs2_v[15:0]}; end
          3'b010:  begin st_w = 4'b1111; st_din = rs2_v; end
          default: ;
        endcase
        if (st_w != '0) dm_addr = rs1_v + imm_s;
      end
      OP_IMM: begin
        rd_we  = 1'b1;
        rd_val = alu(f3, (f3 == 3'b101) && f7[5], rs1_v, imm_i);
      end
      OP_REG: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
        rd_we  = 1'b1;
        rd_val = alu(f3, f7[5], rs1_v, rs2_v);
      end
      default: ;
    endcase
  end

  // Memory strobes are gated by rstn so an instruction aborted by reset never writes.
  assign rom_addr = pc_q;
  assign mem_addr = dm_addr;
  assign mem_r    = rstn & ld_r;
  assign mem_w    = rstn ? st_w : '0;
  assign mem_din  = rstn ? st_din : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc_q <= '0;
    else       pc_q <= pc_d;
  end

`ifdef CPU_REGFILE_RESET_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (rd_we && rd != 5'd0) begin
      regs_q[rd] <= rd_val;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rstn && rd_we && rd != 5'd0) regs_q[rd] <= rd_val;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu.sv
`default_nettype none
// tb_cpu: directed RV32I programs; stores are scoreboarded, PC and memory checked in-line.
module tb_cpu;

  localparam logic [6:0] OPI  = 7'h13;
  localparam logic [6:0] LD   = 7'h03;
  localparam logic [6:0] JALR = 7'h67;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] rom_addr, rom_data, mem_addr, mem_din, mem_dout;
  logic        mem_r;
  logic [3:0]  mem_w;

  logic [31:0] rom [64];
  logic [7:0]  dmem [256];

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [3:0]  w;
    logic [31:0] din;
  } st_exp_t;
  st_exp_t sbq[$];

  int tests = 0;
  int fails = 0;

  cpu #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .rom_addr(rom_addr), .rom_data(rom_data),
    .mem_addr(mem_addr), .mem_r(mem_r), .mem_w(mem_w), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr[7:2]];

  always_comb begin
    mem_dout = '0;
    for (int i = 0; i < 4; i++) mem_dout[8*i +: 8] = dmem[8'(mem_addr + 32'(i))];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_w[i]) dmem[8'(mem_addr + 32'(i))] <= mem_din[8*i +: 8];
  end

  function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3, input int rd,
                                      input logic [6:0] op);
    logic [31:0] m;
    m = imm;
    return {m[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] m;
    m = imm;
    return {m[11:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_t(input int imm, input int rs1, input int rs2, input int f3);
    logic [31:0] m;
    m = imm;
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
  endfunction

  function automatic logic [31:0] j_t(input int imm, input int rd);
    logic [31:0] m;
    m = imm;
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6f};
  endfunction

  function automatic logic [31:0] u_t(input int imm20, input int rd, input logic [6:0] op);
    logic [31:0] m;
    m = imm20;
    return {m[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] r_t(input logic [6:0] f7, input int rs2, input int rs1,
                                      input int f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_st(input string tag, input logic [31:0] a, input logic [3:0] w,
                           input logic [31:0] d);
    st_exp_t e;
    e.tag = tag; e.addr = a; e.w = w; e.din = d;
    sbq.push_back(e);
  endtask

  // Compare any store in flight against the scoreboard, then retire one instruction.
  task automatic tick();
    st_exp_t e;
    if (mem_w !== 4'b0000) begin
      if (sbq.size() == 0) begin
        chk("unexpected_store", {28'd0, mem_w}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk({e.tag, "_addr"}, mem_addr, e.addr);
        chk({e.tag, "_strb"}, {28'd0, mem_w}, {28'd0, e.w});
        chk({e.tag, "_din"}, mem_din, e.din);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input string tag);
    rstn = 1'b0;
    #1;
    chk({tag, "_rst_rom_addr"}, rom_addr, 32'd0);
    chk({tag, "_rst_mem_w"}, {28'd0, mem_w}, 32'd0);
    chk({tag, "_rst_mem_r"}, {31'd0, mem_r}, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) rom[i] = NOP;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    #2;
    // Byte store, signed byte load, byte store of the sum
    hold_reset("A");
    rom[0] = i_t(132, 0, 0, 1, OPI);
    rom[1] = s_t(0, 1, 0, 0);
    rom[2] = i_t(0, 0, 0, 2, LD);
    rom[3] = i_t(100, 2, 0, 2, OPI);
    rom[4] = s_t(1, 2, 0, 0);
    expect_st("A_sb0", 32'd0, 4'b0001, 32'h0000_0084);
    expect_st("A_sb1", 32'd1, 4'b0001, 32'h0000_00E8);
    release_reset();
    tick(); tick();
    chk("A_lb_mem_r", {31'd0, mem_r}, 32'd1);
    chk("A_lb_addr", mem_addr, 32'd0);
    tick();
    chk("A_addi_mem_r", {31'd0, mem_r}, 32'd0);
    tick(); tick();
    chk("A_mem0", {24'd0, dmem[0]}, 32'd132);
    chk("A_mem1", {24'd0, dmem[1]}, 32'd232);
    chk("A_sb_empty", sbq.size(), 32'd0);

    // Word/halfword stores and zero-extending halfword load
    hold_reset("B");
    rom[0] = i_t(-1, 0, 0, 1, OPI);
    rom[1] = s_t(4, 1, 0, 2);
    rom[2] = i_t(4, 0, 5, 2, LD);
    rom[3] = i_t(4, 0, 2, 3, LD);
    rom[4] = s_t(8, 2, 0, 2);
    rom[5] = s_t(12, 3, 0, 2);
    rom[6] = s_t(16, 1, 0, 1);
    expect_st("B_sw", 32'd4, 4'b1111, 32'hFFFF_FFFF);
    expect_st("B_x2", 32'd8, 4'b1111, 32'h0000_FFFF);
    expect_st("B_x3", 32'd12, 4'b1111, 32'hFFFF_FFFF);
    expect_st("B_sh", 32'd16, 4'b0011, 32'h0000_FFFF);
    release_reset();
    tick(); tick();
    chk("B_lhu_addr", mem_addr, 32'd4);
    for (int i = 0; i < 5; i++) tick();
    chk("B_sb_empty", sbq.size(), 32'd0);

    // JAL link and JALR return
    hold_reset("C");
    rom[0] = j_t(8, 1);
    rom[1] = s_t(32, 1, 0, 2);
    rom[2] = i_t(0, 1, 0, 0, JALR);
    expect_st("C_link", 32'd32, 4'b1111, 32'd4);
    release_reset();
    tick(); chk("C_jal_pc", rom_addr, 32'd8);
    tick(); chk("C_jalr_pc", rom_addr, 32'd4);
    tick(); chk("C_after_pc", rom_addr, 32'd8);
    chk("C_sb_empty", sbq.size(), 32'd0);

    // Signed vs unsigned branch compares
    hold_reset("D");
    rom[0] = i_t(-5, 0, 0, 1, OPI);
    rom[1] = b_t(8, 0, 1, 3'b110);
    rom[3] = b_t(8, 0, 1, 3'b100);
    rom[4] = b_t(8, 1, 0, 3'b111);
    rom[6] = b_t(8, 1, 0, 3'b001);
    release_reset();
    tick(); chk("D_pc1", rom_addr, 32'd4);
    tick(); chk("D_bltu_pc", rom_addr, 32'd12);
    tick(); chk("D_blt_pc", rom_addr, 32'd16);
    tick(); chk("D_bgeu_pc", rom_addr, 32'd24);
    tick(); chk("D_bne_pc", rom_addr, 32'd32);

    // x0 discard, LUI, AUIPC, SUB, shifts, SLT/SLTU, ECALL as NOP
    hold_reset("E");
    rom[0]  = i_t(5, 0, 0, 0, OPI);
    rom[1]  = r_t(7'h00, 0, 0, 0, 1);
    rom[2]  = u_t(1, 3, 7'h17);
    rom[3]  = u_t('h12345, 2, 7'h37);
    rom[4]  = s_t(40, 1, 0, 2);
    rom[5]  = s_t(44, 2, 0, 2);
    rom[6]  = s_t(48, 3, 0, 2);
    rom[7]  = r_t(7'h20, 3, 0, 0, 4);
    rom[8]  = i_t('h404, 4, 5, 5, OPI);
    rom[9]  = i_t(4, 4, 5, 6, OPI);
    rom[10] = r_t(7'h00, 0, 4, 2, 7);
    rom[11] = r_t(7'h00, 0, 4, 3, 8);
    rom[12] = s_t(52, 5, 0, 2);
    rom[13] = s_t(56, 6, 0, 2);
    rom[14] = s_t(60, 7, 0, 2);
    rom[15] = s_t(64, 8, 0, 2);
    rom[16] = 32'h0000_0073;
    expect_st("E_x1", 32'd40, 4'b1111, 32'd0);
    expect_st("E_lui", 32'd44, 4'b1111, 32'h1234_5000);
    expect_st("E_auipc", 32'd48, 4'b1111, 32'h0000_1008);
    expect_st("E_srai", 32'd52, 4'b1111, 32'hFFFF_FEFF);
    expect_st("E_srli", 32'd56, 4'b1111, 32'h0FFF_FEFF);
    expect_st("E_slt", 32'd60, 4'b1111, 32'd1);
    expect_st("E_sltu", 32'd64, 4'b1111, 32'd0);
    release_reset();
    for (int i = 0; i < 16; i++) tick();
    chk("E_ecall_mem_w", {28'd0, mem_w}, 32'd0);
    tick();
    chk("E_ecall_pc", rom_addr, 32'd68);
    chk("E_sb_empty", sbq.size(), 32'd0);

    // Reset pulsed mid-cycle while a store is being presented
    hold_reset("F");
    rom[0] = i_t(7, 0, 0, 1, OPI);
    rom[1] = s_t(32, 1, 0, 2);
    expect_st("F_sw", 32'd32, 4'b1111, 32'd7);
    release_reset();
    tick();
    chk("F_pre_pc", rom_addr, 32'd4);
    rstn = 1'b0;
    #1;
    chk("F_mid_rom_addr", rom_addr, 32'd0);
    chk("F_mid_mem_w", {28'd0, mem_w}, 32'd0);
    @(posedge clk);
    #1;
    chk("F_held_rom_addr", rom_addr, 32'd0);
    chk("F_held_mem_w", {28'd0, mem_w}, 32'd0);
    release_reset();
    tick(); chk("F_restart_pc", rom_addr, 32'd4);
    tick(); chk("F_store_pc", rom_addr, 32'd8);
    chk("F_mem32", {24'd0, dmem[32]}, 32'd7);
    chk("F_sb_empty", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
